instr_feeder: RTL

//   Instruction sequencer that drives the CPU's instruction port.

---
 rtl/instr_feeder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/instr_feeder.sv
// Instruction sequencer: fetches program words and issues them to the CPU
// with a load/start/wait handshake, flagging handshake timeouts.
module instr_feeder #(
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic [ADDR_W:0]   prog_len,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [15:0]       mem_data,
   output logic [15:0]       cpu_in,
   output logic              cpu_load,
   output logic              cpu_s,
   input  logic              cpu_w,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   pc
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      MEMWT,
      RDY,
      LOAD,
      START,
      EXEC,
      DONE
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [ADDR_W:0] pc_next;
   logic            halt;
   logic            timed_out;

   assign pc_next   = pc + 1'b1;
   assign halt      = (mem_data[15:13] == 3'b111);
   assign timed_out = (cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         mem_addr <= '0;
         cpu_in   <= '0;
         cpu_load <= 1'b0;
         cpu_s    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         pc       <= '0;
      end else begin
         cpu_load <= 1'b0;
         cpu_s    <= 1'b0;
         cnt      <= cnt + 1'b1;
         unique case (state)
            IDLE, DONE: begin
               cnt <= '0;
               if (go) begin
                  err <= 1'b0;
                  pc  <= '0;
                  if (prog_len != '0) begin
                     state    <= FETCH;
                     mem_addr <= '0;
                     busy     <= 1'b1;
                     done     <= 1'b0;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            FETCH: begin
               cnt   <= '0;
               state <= MEMWT;
            end
            MEMWT: begin
               cnt    <= '0;
               cpu_in <= mem_data;
               if (halt) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= RDY;
               end
            end
            RDY: begin
               if (cpu_w) begin
                  cnt      <= '0;
                  state    <= LOAD;
                  cpu_load <= 1'b1;
               end else if (timed_out) begin
                  cnt   <= '0;
                  state <= DONE;
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            LOAD: begin
               cnt   <= '0;
               state <= START;
               cpu_s <= 1'b1;
            end
            START: begin
               cnt   <= '0;
               state <= EXEC;
            end
            EXEC: begin
               // >= guards against prog_len shrinking mid-run
               if (cpu_w) begin
                  cnt <= '0;
                  pc  <= pc_next;
                  if (pc_next >= prog_len) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state    <= FETCH;
                     mem_addr <= pc_next[ADDR_W-1:0];
                  end
               end else if (timed_out) begin
                  cnt   <= '0;
                  state <= DONE;
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
